fifo36_tx_scheduler: RTL
========================

// Module: fifo36_tx_scheduler
// PURPOSE
//  Packet-level round-robin scheduler feeding the write side of one 36-bit dual-clock FIFO (TX path).
//  It picks one of NUM_PORTS 36-bit packet sources and forwards that packet. A packet starts only if the
//  FIFO 'space' count shows room for the whole packet, so a packet never stalls half-written.
//  It also drops malformed packets and counts errors. Sits entirely in the FIFO write-clock domain.
// PARAMETERS
//  NUM_PORTS  4   number of packet sources (2..8)
//  MAX_LEN    64  largest legal packet in words; matches the 64-deep TX FIFO
// PORTS
//  clk          in   1            write-side clock
//  rst_n        in   1            synchronous reset, active low
//  in_data      in   36*NUM_PORTS source words; port i at [36*i+35:36*i]
//  in_src_rdy   in   NUM_PORTS    source i has a valid word
//  in_dst_rdy   out  NUM_PORTS    word of source i consumed this cycle
//  out_data     out  36           word to FIFO datain
//  out_src_rdy  out  1            to FIFO src_rdy_i
//  out_dst_rdy  in   1            from FIFO dst_rdy_o (~full)
//  fifo_space   in   16           FIFO free words (write-clock view)
//  busy         out  1            high in XFER or DROP
//  grant        out  3            port currently granted (valid when busy)
//  pkt_count    out  32           packets forwarded; wraps
//  err_count    out  16           malformed packets/words; saturates at 16'hFFFF
// BEHAVIOUR
//  Word format: bit32 = SOF, bit33 = EOF, [35:34] = occupancy (passed through unchanged).
//   On the SOF word, [15:0] = packet length in words, SOF word included.
//  Reset (rst_n=0 at a clk edge): state=IDLE, last=NUM_PORTS-1, all in_dst_rdy=0, out_src_rdy=0,
//   out_data=0, busy=0, grant=0, counters=0. Reset mid-packet truncates the packet; downstream is
//   reset together with this block.
//  IDLE: scan ports round-robin from (last+1) mod NUM_PORTS; pick the first port i with in_src_rdy[i]=1.
//   - Head word has no SOF: set in_dst_rdy[i]=1 for this one cycle to discard it; err_count++; stay in IDLE.
//   - SOF and len==0 or len>MAX_LEN: register grant=i and go to DROP; err_count++.
//   - SOF and legal len, and fifo_space >= len: register grant=i, remain=len, last=i; go to XFER.
//   - SOF and legal len, but space too small: skip this port this cycle and try the next eligible one.
//     This prevents head-of-line blocking.
//   - IDLE never drives out_src_rdy. There is one bubble cycle from grant decision to first transfer.
//  XFER (combinational pass-through from port g):
//   - out_data = in_data[g], out_src_rdy = in_src_rdy[g], in_dst_rdy[g] = out_dst_rdy; all other in_dst_rdy = 0.
//   - A transfer happens when in_src_rdy[g] & out_dst_rdy. On each transfer, remain decrements.
//   - Transfer with EOF: pkt_count++ and go to IDLE. If remain was >1 (short packet), also err_count++.
//   - Transfer with remain==1 and no EOF: force out_data[33]=1 on that word, pkt_count++, err_count++,
//     then go to DROP to discard the tail.
//   - SOF seen on a non-first word: forwarded as data; no special action.
//  DROP: in_dst_rdy[g] = in_src_rdy[g], out_src_rdy = 0; consume words until the EOF word, then go to IDLE.
//  Counter saturation and simultaneous events:
//   - One cycle can both increment pkt_count and increment err_count.
//   - err_count holds at max value.
//  Width rules: len compared as 16-bit unsigned against fifo_space; remain is clog2(MAX_LEN+1) bits.
// STRUCTURE
//  Shared package/header fifo36_defs: SOF_BIT=32, EOF_BIT=33, OCC_MSB=35, OCC_LSB=34, LEN_MSB=15,
//   and the state encoding IDLE=2'd0, XFER=2'd1, DROP=2'd2.
//  Sub-module rr_pick #(N): inputs req[N] and last; outputs a one-hot grant and a valid flag.
//   Purely combinational; used in IDLE with req = eligible ports.
//  Top level holds the state machine, remain counter, output mux and counters.
// TESTING
//  1 Port0 sends a 4-word packet (len=4, EOF on word 4), space=65, out_dst_rdy=1
//    -> 4 transfers starting 1 cycle after grant; pkt_count=1; err_count=0.
//  2 Ports 0..3 each send a 2-word packet at once, last=3
//    -> service order 0,1,2,3; total 12 cycles, with one bubble between packets.
//  3 Port0 len=10 with space=8; port1 len=3
//    -> port1 is forwarded first; port0 starts once space>=10.
//  4 Port2 len=3 but EOF on word 5
//    -> 3 words out, third has EOF forced; words 4-5 dropped; err_count=1; pkt_count=1.
//  5 Head word without SOF, then len=0 packet, then len=65 packet
//    -> err_count=3; nothing written; every word consumed.
//  6 rst_n=0 for 1 cycle during word 2 of a 5-word packet with out_dst_rdy toggling
//    -> next cycle all outputs are at reset values and state=IDLE.

Source files
------------

// File: rtl/fifo36_tx_scheduler_pkg.sv
// Shared word-format fields, state encoding and length check for the 36-bit TX scheduler.
package fifo36_tx_scheduler_pkg;

    localparam int unsigned SOF_BIT = 32;
    localparam int unsigned EOF_BIT = 33;
    localparam int unsigned OCC_MSB = 35;
    localparam int unsigned OCC_LSB = 34;
    localparam int unsigned LEN_MSB = 15;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] XFER = 2'd1;
    localparam logic [1:0] DROP = 2'd2;

    typedef logic [35:0] word_t;

    function automatic logic len_bad(input logic [LEN_MSB:0] len, input logic [LEN_MSB:0] max_len);
        return (len == '0) || (len > max_len);
    endfunction

endpackage

// File: rtl/fifo36_tx_scheduler_if.sv
// Source-side and FIFO-side handshake bundle of the TX scheduler.
interface fifo36_tx_scheduler_if #(
    parameter int unsigned NUM_PORTS = 4
);
    logic [36*NUM_PORTS-1:0] in_data;
    logic [NUM_PORTS-1:0]    in_src_rdy;
    logic [NUM_PORTS-1:0]    in_dst_rdy;
    logic [35:0]             out_data;
    logic                    out_src_rdy;
    logic                    out_dst_rdy;
    logic [15:0]             fifo_space;

    modport master (
        input  in_data, in_src_rdy, out_dst_rdy, fifo_space,
        output in_dst_rdy, out_data, out_src_rdy
    );

    modport slave (
        output in_data, in_src_rdy, out_dst_rdy, fifo_space,
        input  in_dst_rdy, out_data, out_src_rdy
    );
endinterface

// File: rtl/fifo36_tx_scheduler_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', one-hot result.
module rr_pick #(
    parameter  int unsigned N  = 4,
    localparam int unsigned LW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [LW-1:0] last,
    output logic [N-1:0]  grant,
    output logic          valid
);
    logic [LW-1:0] idx;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = LW'((32'(last) + k) % N);
            if (!valid && req[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/fifo36_tx_scheduler.sv
// Packet-level round-robin scheduler feeding one 36-bit TX FIFO; only starts packets that fit.
module fifo36_tx_scheduler
    import fifo36_tx_scheduler_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned MAX_LEN   = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fifo36_tx_scheduler_if.master bus,
    output logic                 busy,
    output logic [2:0]           grant,
    output logic [31:0]          pkt_count,
    output logic [15:0]          err_count
);
    localparam int unsigned LW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned RW = $clog2(MAX_LEN + 1);
    localparam logic [15:0] MAX_LEN16 = 16'(MAX_LEN);

    logic [1:0]           state;
    logic [LW-1:0]        gnt_q, last_q, pick_idx;
    logic [RW-1:0]        remain;
    word_t                words [NUM_PORTS];
    word_t                cur;
    logic [NUM_PORTS-1:0] eligible, pick_oh;
    logic                 pick_valid, pick_sof, pick_bad, xfer, pkt_inc, err_inc;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_words
        assign words[i] = bus.in_data[36*i +: 36];
    end

    // A well-formed head that does not fit is skipped so other ports are not blocked behind it.
    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            eligible[i] = bus.in_src_rdy[i] &&
                          (!words[i][SOF_BIT] || len_bad(words[i][LEN_MSB:0], MAX_LEN16) ||
                           (bus.fifo_space >= words[i][LEN_MSB:0]));
        end
    end

    rr_pick #(.N(NUM_PORTS)) u_pick (
        .req   (eligible),
        .last  (last_q),
        .grant (pick_oh),
        .valid (pick_valid)
    );

    always_comb begin
        pick_idx = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (pick_oh[i]) pick_idx = LW'(i);
        end
    end

    assign cur      = words[gnt_q];
    assign pick_sof = words[pick_idx][SOF_BIT];
    assign pick_bad = len_bad(words[pick_idx][LEN_MSB:0], MAX_LEN16);
    assign xfer     = (state == XFER) && bus.in_src_rdy[gnt_q] && bus.out_dst_rdy;
    assign pkt_inc  = xfer && (cur[EOF_BIT] || (remain == RW'(1)));
    assign err_inc  = ((state == IDLE) && pick_valid && (!pick_sof || pick_bad)) ||
                      (xfer && ((cur[EOF_BIT] && (remain > RW'(1))) ||
                                (!cur[EOF_BIT] && (remain == RW'(1)))));

    always_comb begin
        bus.in_dst_rdy  = '0;
        bus.out_data    = '0;
        bus.out_src_rdy = 1'b0;
        case (state)
            IDLE: bus.in_dst_rdy[pick_idx] = pick_valid && !pick_sof;
            XFER: begin
                bus.out_data = cur;
                // Last word of the declared length always leaves as EOF; the tail is dropped.
                if (remain == RW'(1)) bus.out_data[EOF_BIT] = 1'b1;
                bus.out_src_rdy       = bus.in_src_rdy[gnt_q];
                bus.in_dst_rdy[gnt_q] = bus.out_dst_rdy;
            end
            DROP:    bus.in_dst_rdy[gnt_q] = bus.in_src_rdy[gnt_q];
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt_q     <= '0;
            last_q    <= LW'(NUM_PORTS - 1);
            remain    <= '0;
            pkt_count <= '0;
            err_count <= '0;
        end else begin
            if (pkt_inc) pkt_count <= pkt_count + 32'd1;
            if (err_inc && (err_count != '1)) err_count <= err_count + 16'd1;
            case (state)
                IDLE: begin
                    if (pick_valid && pick_sof) begin
                        gnt_q <= pick_idx;
                        if (pick_bad) begin
                            state <= DROP;
                        end else begin
                            remain <= words[pick_idx][RW-1:0];
                            last_q <= pick_idx;
                            state  <= XFER;
                        end
                    end
                end
                XFER: begin
                    if (xfer) begin
                        remain <= remain - 1'b1;
                        if (cur[EOF_BIT])             state <= IDLE;
                        else if (remain == RW'(1))    state <= DROP;
                    end
                end
                DROP: begin
                    if (bus.in_src_rdy[gnt_q] && cur[EOF_BIT]) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy  = (state != IDLE);
    assign grant = 3'(gnt_q);
endmodule
